// File: rtl/mmio_pkg.sv
// Shared constants for the mmio_periph register window: register offsets
// relative to BASE and the window size.
package mmio_pkg;

  localparam int unsigned MMIO_WIN = 4;

  localparam logic [1:0] OFF_BTN_STATE = 2'd0;
  localparam logic [1:0] OFF_LED       = 2'd1;
  localparam logic [1:0] OFF_BRIGHT    = 2'd2;
  localparam logic [1:0] OFF_BTN_EDGE  = 2'd3;

endpackage

// File: rtl/RAM.sv
// Shared data memory: synchronous write, combinational read, no reset so
// contents survive a peripheral reset.
module RAM #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (wEn) mem[addr] <= dataIn;
  end

  assign dataOut = mem[addr];

endmodule

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a counter debouncer when
// MMIO_DEBOUNCE_EN is defined; otherwise the synchroniser output is the state.
module btn_debounce
  import mmio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic state,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic sync_p0, sync_p1;

  // stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             state_q;
  logic             flip;

  // flip is the cycle on which the state changes, so rise lines up with it
  assign flip  = (sync_p1 != state_q) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign state = state_q;
  assign rise  = flip & ~state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      state_q <= 1'b0;
    end else if (sync_p1 == state_q) begin
      cnt <= '0;
    end else if (flip) begin
      cnt     <= '0;
      state_q <= ~state_q;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign state = sync_p1;
  assign rise  = sync_p0 & ~sync_p1;
`endif

endmodule

// File: rtl/mmio_periph.sv
// MMIO front end on the data port: button/LED register window at BASE, all
// other addresses pass through to RAM. Debouncing is enabled by MMIO_DEBOUNCE_EN.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned NUM_LED         = 16,
  parameter int unsigned BRIGHT_W        = 4,
  parameter logic [11:0] BASE            = 12'd1000,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wEn,
  input  logic                rEn,
  input  logic [11:0]         addr,
  input  logic [31:0]         dataIn,
  output logic [31:0]         dataOut,
  input  logic [NUM_BTN-1:0]  btn,
  output logic [NUM_LED-1:0]  led,
  output logic [BRIGHT_W-1:0] brightness
);

  logic                in_win;
  logic [1:0]          off;
  logic                sel_edge;
  logic [NUM_BTN-1:0]  btn_state, btn_rise, edge_q, edge_clr;
  logic [NUM_LED-1:0]  led_q;
  logic [BRIGHT_W-1:0] bright_q, pwm_cnt;
  logic [31:0]         reg_rd, ram_rd;

  // 13-bit compare so a window near the top of the address space cannot wrap
  assign in_win   = ({1'b0, addr} >= {1'b0, BASE}) &&
                    ({1'b0, addr} <  ({1'b0, BASE} + 13'(MMIO_WIN)));
  assign off      = addr[1:0] - BASE[1:0];
  assign sel_edge = in_win && (off == OFF_BTN_EDGE);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn[i]),
      .state (btn_state[i]),
      .rise  (btn_rise[i])
    );
  end

  always_comb begin
    edge_clr = '0;
    if (rEn && sel_edge) edge_clr = '1;
    if (wEn && sel_edge) edge_clr = edge_clr | dataIn[NUM_BTN-1:0];
  end

  // a rising edge on this cycle wins over any clear of the same bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q    <= '0;
      bright_q <= '0;
      edge_q   <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      edge_q  <= (edge_q & ~edge_clr) | btn_rise;
      if (wEn && in_win && (off == OFF_LED))    led_q    <= dataIn[NUM_LED-1:0];
      if (wEn && in_win && (off == OFF_BRIGHT)) bright_q <= dataIn[BRIGHT_W-1:0];
    end
  end

  always_comb begin
    reg_rd = '0;
    case (off)
      OFF_BTN_STATE: reg_rd[NUM_BTN-1:0]  = btn_state;
      OFF_LED:       reg_rd[NUM_LED-1:0]  = led_q;
      OFF_BRIGHT:    reg_rd[BRIGHT_W-1:0] = bright_q;
      default:       reg_rd[NUM_BTN-1:0]  = edge_q;
    endcase
  end

  RAM #(.ADDR_W(12), .DATA_W(32)) u_ram (
    .clk     (clk),
    .wEn     (wEn & ~in_win),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (ram_rd)
  );

  assign dataOut    = in_win ? reg_rd : ram_rd;
  assign led        = led_q & {NUM_LED{pwm_cnt < bright_q}};
  assign brightness = bright_q;

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_mmio_periph;

  localparam int          NB   = 5;
  localparam int          NL   = 16;
  localparam int          BW   = 4;
  localparam int          DEB  = 4;
  localparam logic [11:0] BASE = 12'd1000;
`ifdef MMIO_DEBOUNCE_EN
  localparam int          LAT       = 2 + DEB;
  localparam logic [31:0] PULSE_EXP = 32'h0;
`else
  localparam int          LAT       = 2;
  localparam logic [31:0] PULSE_EXP = 32'h1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wEn = 1'b0, rEn = 1'b0;
  logic [11:0]   addr = '0;
  logic [31:0]   dataIn = '0;
  logic [31:0]   dataOut;
  logic [NB-1:0] btn = '0;
  logic [NL-1:0] led;
  logic [BW-1:0] brightness;

  always #5 clk = ~clk;

  mmio_periph #(
    .NUM_BTN(NB), .NUM_LED(NL), .BRIGHT_W(BW), .BASE(BASE), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wEn(wEn), .rEn(rEn), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .btn(btn), .led(led), .brightness(brightness)
  );

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [NL-1:0] m_led;
  logic [BW-1:0] m_bright;
  logic [NB-1:0] m_edge, m_deb;
  int            m_pwm;
  logic [NB-1:0] hist [0:7];   // hist[k] = raw btn sampled k edges ago
  logic [31:0]   m_ram [int];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(logic [11:0] a);
    return (a >= BASE) && (a <= BASE + 12'd3);
  endfunction

  function automatic logic [31:0] exp_reg(logic [11:0] a);
    case (int'(a) - int'(BASE))
      0:       return {27'b0, m_deb};
      1:       return {16'b0, m_led};
      2:       return {28'b0, m_bright};
      default: return {27'b0, m_edge};
    endcase
  endfunction

  // State after a clock edge, from the inputs present at that edge.
  task automatic model_update();
    logic [NB-1:0] nd, clr;
    if (wEn && !in_win(addr)) m_ram[int'(addr)] = dataIn;
    if (!rst_n) begin
      m_led = '0; m_bright = '0; m_edge = '0; m_deb = '0; m_pwm = 0;
      for (int k = 0; k < 8; k++) hist[k] = '0;
    end else begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn;
      nd = m_deb;
`ifdef MMIO_DEBOUNCE_EN
      // state flips once DEB consecutive synchronised samples disagree with it
      for (int b = 0; b < NB; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 2; k <= DEB + 1; k++)
          if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) nd[b] = ~m_deb[b];
      end
`else
      nd = hist[1];
`endif
      clr = '0;
      if (rEn && addr == BASE + 12'd3) clr = '1;
      if (wEn && addr == BASE + 12'd3) clr = clr | dataIn[NB-1:0];
      m_edge = (m_edge & ~clr) | (nd & ~m_deb);
      m_deb  = nd;
      if (wEn && addr == BASE + 12'd1) m_led    = dataIn[NL-1:0];
      if (wEn && addr == BASE + 12'd2) m_bright = dataIn[BW-1:0];
      m_pwm = (m_pwm + 1) % (1 << BW);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("led", {16'b0, led}, {16'b0, (m_pwm < int'(m_bright)) ? m_led : 16'h0});
      check("brightness", {28'b0, brightness}, {28'b0, m_bright});
      if (in_win(addr)) check("reg_read", dataOut, exp_reg(addr));
      else if (m_ram.exists(int'(addr))) check("ram_read", dataOut, m_ram[int'(addr)]);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d);
    addr = a; dataIn = d; wEn = 1'b1;
    tick();
    wEn = 1'b0;
  endtask

  task automatic rd_now(logic [11:0] a, logic [31:0] exp, string name);
    addr = a;
    #1;
    check(name, dataOut, exp);
  endtask

  initial begin
    int on, bad, r;

    // reset
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    rd_now(BASE,         32'h0, "rst_btn_state");
    rd_now(BASE + 12'd1, 32'h0, "rst_led_reg");
    check("rst_led_out", {16'b0, led}, 32'h0);
    check("rst_brightness", {28'b0, brightness}, 32'h0);
    tick();
    rd_now(BASE + 12'd2, 32'h0, "rst_bright_reg");
    rd_now(BASE + 12'd3, 32'h0, "rst_btn_edge");

    // LED / PWM
    wr(BASE + 12'd1, 32'h0000_A5A5);
    wr(BASE + 12'd2, 32'h4);
    on = 0; bad = 0;
    repeat (16) begin
      tick();
      if (led == 16'hA5A5) on++;
      else if (led != 16'h0) bad++;
    end
    check("pwm_on_cycles", on, 4);
    check("pwm_bad_pattern", bad, 0);
    wr(BASE + 12'd2, 32'h0);
    on = 0;
    repeat (16) begin
      tick();
      if (led != 16'h0) on++;
    end
    check("pwm_bright0_off", on, 0);
    wr(BASE + 12'd2, 32'hFFFF_FFF9);
    wr(BASE + 12'd1, 32'hFFFF_A5A5);
    rd_now(BASE + 12'd2, 32'h9, "bright_upper_zero");
    rd_now(BASE + 12'd1, 32'h0000_A5A5, "led_upper_zero");
    wr(BASE, 32'hFFFF_FFFF);
    rd_now(BASE, 32'h0, "btn_state_readonly");

    // debounce
`ifdef MMIO_DEBOUNCE_EN
    btn = 5'b00100;
    tick(3);
    btn = '0;
    bad = 0;
    repeat (12) begin
      tick();
      addr = BASE;
      #1;
      if (dataOut != 32'h0) bad++;
    end
    check("glitch_ignored", bad, 0);
`endif
    btn = 5'b00100;
    tick(LAT - 1);
    rd_now(BASE,         32'h0, "state_before_latency");
    rd_now(BASE + 12'd3, 32'h0, "edge_before_latency");
    tick();
    rd_now(BASE,         32'h4, "state_at_latency");
    rd_now(BASE + 12'd3, 32'h4, "edge_at_latency");

    // read-to-clear returns the pre-clear value
    addr = BASE + 12'd3; rEn = 1'b1;
    #1;
    check("read_clear_pre", dataOut, 32'h4);
    tick();
    rEn = 1'b0;
    rd_now(BASE + 12'd3, 32'h0, "read_clear_post");

    // W1C clears only the written bits
    btn = '0;
    tick(LAT + 2);
    btn = 5'b00101;
    tick(LAT + 1);
    rd_now(BASE + 12'd3, 32'h5, "edges_both_set");
    wr(BASE + 12'd3, 32'h1);
    rd_now(BASE + 12'd3, 32'h4, "w1c_bit0_only");

    // a new edge in the same cycle as a clear survives
    btn = '0;
    tick(LAT + 2);
    addr = BASE + 12'd3; rEn = 1'b1;
    tick();
    rEn = 1'b0;
    rd_now(BASE + 12'd3, 32'h0, "edges_cleared");
    btn = 5'b00010;
    tick(LAT - 1);
    addr = BASE + 12'd3; rEn = 1'b1; wEn = 1'b1; dataIn = 32'h2;
    #1;
    check("same_cycle_pre", dataOut, 32'h0);
    tick();
    rEn = 1'b0; wEn = 1'b0;
    rd_now(BASE + 12'd3, 32'h2, "set_beats_clear");

    // single-cycle raw pulse: captured only without the debouncer
    btn = '0;
    tick(LAT + 2);
    addr = BASE + 12'd3; rEn = 1'b1;
    tick();
    rEn = 1'b0;
    btn = 5'b00001;
    tick();
    btn = '0;
    tick(3);
    rd_now(BASE + 12'd3, PULSE_EXP, "pulse_edge");
    rd_now(BASE, 32'h0, "pulse_state_gone");

    // window vs RAM
    wr(12'd5, 32'hDEAD_BEEF);
    wr(BASE + 12'd1, 32'h3);
    rd_now(12'd5, 32'hDEAD_BEEF, "ram_addr5");
    rd_now(BASE + 12'd1, 32'h3, "window_led_reg");
    wr(BASE - 12'd1, 32'h1234_5678);
    wr(BASE + 12'd4, 32'hCAFE_F00D);
    rd_now(BASE - 12'd1, 32'h1234_5678, "ram_below_window");
    rd_now(BASE + 12'd4, 32'hCAFE_F00D, "ram_above_window");

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 399) != 0);
      wEn    = ($urandom_range(0, 3) == 0);
      rEn    = ($urandom_range(0, 3) == 0);
      dataIn = $urandom();
      r      = $urandom_range(0, 9);
      if (r < 4)       addr = BASE + 12'(r);
      else if (r == 4) addr = BASE - 12'd1;
      else if (r == 5) addr = BASE + 12'd4;
      else             addr = 12'(r - 6);
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 4) == 0) btn[b] = ~btn[b];
      tick();
    end
    rst_n = 1'b1; wEn = 1'b0; rEn = 1'b0;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mmio_periph.md
# mmio_periph

Parametrised memory-mapped peripheral front end for the soft processor's data memory port. It wraps the shared `RAM` and decodes a small register window for buttons and LEDs. It generalises the earlier single-button, 5-LED wrapper with:
- N buttons, synchronised and debounced, with sticky rising-edge capture
- N LEDs with hardware PWM dimming
- a read strobe so status registers can clear on read

## Interface
Parameters:
- `NUM_BTN`, 5, number of button inputs (1..32)
- `NUM_LED`, 16, number of LED outputs (1..32)
- `BRIGHT_W`, 4, brightness/PWM resolution in bits (1..16)
- `BASE`, 1000, word address of first MMIO register (12-bit)
- `DEBOUNCE_CYCLES`, 65536, stable cycles required before a button change is accepted (>=2)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  synchronous, active-low reset
- `wEn`  in  1  write strobe
- `rEn`  in  1  read strobe; qualifies read-to-clear side effects only
- `addr`  in  12  word address
- `dataIn`  in  32  write data
- `dataOut`  out  32  read data
- `btn`  in  NUM_BTN  raw asynchronous button inputs
- `led`  out  NUM_LED  PWM-gated LED drive
- `brightness`  out  BRIGHT_W  current brightness register value

## Operation
Address map (offsets from `BASE`):
- +0 BTN_STATE (R): debounced state, bits [NUM_BTN-1:0]
- +1 LED (RW): LED enable mask, bits [NUM_LED-1:0]
- +2 BRIGHT (RW): bits [BRIGHT_W-1:0]
- +3 BTN_EDGE (R/W1C): sticky rising-edge flags
  - cleared as a whole on `rEn`
  - bits written 1 are cleared

Register behaviour:
- Unused upper bits read 0. Writes to +0 are ignored.
- Addresses outside BASE..BASE+3 go to `RAM`, with its data returned unchanged.
- Writes inside the window are not forwarded to `RAM`.

Button path, per bit:
- Two-flop synchroniser, then debouncer.
- Debouncer counter clears while the synced input equals the debounced state. Otherwise it increments.
- When the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, the debounced state flips and the counter clears.

Edge capture:
- A 0->1 flip of the debounced state sets the matching BTN_EDGE bit on the same clock edge.
- Set has priority over a clear (read or W1C) in the same cycle; that bit remains 1.

PWM:
- Free-running `BRIGHT_W`-bit counter.
- pwm_on = (counter < BRIGHT), giving duty BRIGHT/2^BRIGHT_W. BRIGHT=0 is always off.
- `led` = LED & {NUM_LED{pwm_on}}.

Reset (`rst_n`=0 at a clock edge):
- LED, BRIGHT, BTN_EDGE, debounced state, debounce counters, synchronisers and PWM counter all go to 0.
- `led`=0 and `brightness`=0.
- RAM contents are untouched.
- Reset mid-debounce discards the partial count.

## Timing
- Register writes take effect on the `clk` edge where `wEn`=1. The new value is visible on `dataOut`, `brightness` and `led` gating from the next cycle.
- MMIO `dataOut` is combinational on `addr` and current register state, with no added latency. RAM reads keep `RAM`'s native latency.
- Button press latency from a stable raw input to BTN_STATE/BTN_EDGE: 2 (sync) + DEBOUNCE_CYCLES cycles.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- PWM period is 2^BRIGHT_W cycles. A brightness change applies to the current period immediately; no glitch filtering.
- Read-to-clear occurs on the edge where `rEn`=1 and addr=BASE+3. Data returned in that cycle is the pre-clear value.

## Configuration
- `MMIO_DEBOUNCE_EN`
  - Defined: debouncer present as described.
  - Undefined: the debounced state equals the synchroniser output. Latency is 2 cycles, DEBOUNCE_CYCLES is ignored and no counters are built.
- Edge capture and all registers are identical in both builds.

## Structure
- Shared package `mmio_pkg`:
  - register offset constants: OFF_BTN_STATE=0, OFF_LED=1, OFF_BRIGHT=2, OFF_BTN_EDGE=3
  - MMIO window size constant (4)
- Sub-module `btn_debounce`: one per button, generated NUM_BTN times. It contains the synchroniser, counter and debounced output, with the macro guard inside.
- The top level holds the decode, registers, edge capture, PWM and the `RAM` instance.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, NUM_BTN=5, NUM_LED=16, BRIGHT_W=4.
- Reset: hold `rst_n`=0 for 3 cycles, then read +0..+3 -> all 0, `led`=0, `brightness`=0.
- LED/PWM: write LED=0xA5A5 and BRIGHT=4 -> `led`=0xA5A5 for 4 of every 16 cycles, else 0. BRIGHT=0 -> `led` constantly 0.
- Debounce:
  - btn[2]=1 for 3 cycles, then 0 -> BTN_STATE stays 0.
  - btn[2] held 1 -> BTN_STATE=0x04 and BTN_EDGE=0x04 exactly 6 cycles later.
- Edge clear:
  - read +3 with `rEn` -> returns 0x04; the next read returns 0.
  - with flags set, write 0x01 to +3 -> only bit0 clears.
  - a new edge in the same cycle as a clear -> that bit stays 1.
- Window/RAM: write 0xDEADBEEF to addr 5, and 0x3 to BASE+1 -> addr 5 reads 0xDEADBEEF, BASE+1 reads 0x3, RAM[BASE+1] unchanged.
- Macro off: rebuild without `MMIO_DEBOUNCE_EN` -> btn[0] rise is visible in BTN_STATE after 2 cycles, and a 1-cycle pulse that is sampled is captured in BTN_EDGE.
